wavetable_reader: RTL and testbench

- Read-side initiator for the registered 1-cycle-latency wavetable ROM used by the oscillators.
- Each accepted sample request does the following:
  - Holds a phase accumulator.
  - Fetches two adjacent table entries over the ROM addr/data interface.
  - Linearly interpolates between them using fractional phase bits.
  - Emits one sample with a valid strobe.
- Sits between the voice/pitch logic (phase_inc) and the per-voice mixer.

---
 rtl/synth_pkg.sv | 18 +
 rtl/wavetable_reader_lerp.sv | 48 ++++
 rtl/wavetable_reader.sv | 122 ++++++++++++
 tb/tb_wavetable_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and default widths for the oscillator/synth datapath blocks.
package synth_pkg;

  localparam int WT_ADDR_W = 7;
  localparam int WT_DATA_W = 32;
  localparam int WT_FRAC_W = 8;
  localparam int PHASE_W   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    CAP_B   = 3'd3,
    LERP    = 3'd4,
    OUT     = 3'd5
  } wt_state_t;

endpackage

// File: rtl/wavetable_reader_lerp.sv
// Two-step linear interpolator: registered (b-a)*frac, then a + (prod >>> FRAC_W).
// The floor-rounded result always lies between a and b, so it fits DATA_W.
module lerp
  import synth_pkg::*;
#(
  parameter int DATA_W = WT_DATA_W,
  parameter int FRAC_W = WT_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mul_en,
  input  logic              i_add_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [FRAC_W-1:0] i_frac,
  output logic [DATA_W-1:0] o_result
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic signed [DATA_W:0]   w_diff;
  logic signed [PROD_W-1:0] w_diff_x;
  logic signed [PROD_W-1:0] w_frac_x;
  logic signed [PROD_W-1:0] r_prod;
  logic        [DATA_W-1:0] r_result;

  // The fraction is unsigned, so it is zero-extended before the signed multiply.
  assign w_diff   = {i_b[DATA_W-1], i_b} - {i_a[DATA_W-1], i_a};
  assign w_diff_x = {{(FRAC_W+1){w_diff[DATA_W]}}, w_diff};
  assign w_frac_x = {{(DATA_W+2){1'b0}}, i_frac};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      if (i_mul_en) begin
        r_prod <= w_diff_x * w_frac_x;
      end
      if (i_add_en) begin
        r_result <= i_a + DATA_W'(r_prod >>> FRAC_W);
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/wavetable_reader.sv
// Wavetable read initiator: phase accumulator, two-entry ROM fetch and linear
// interpolation, producing one sample every six cycles at most.
module wavetable_reader #(
  parameter int ADDR_W  = synth_pkg::WT_ADDR_W,
  parameter int DATA_W  = synth_pkg::WT_DATA_W,
  parameter int PHASE_W = synth_pkg::PHASE_W,
  parameter int FRAC_W  = synth_pkg::WT_FRAC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               phase_sync,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  import synth_pkg::*;

  wt_state_t          r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [ADDR_W-1:0]  r_idx;
  logic [FRAC_W-1:0]  r_frac;
  logic [DATA_W-1:0]  r_a;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_valid;
  logic               r_busy;
  logic               r_overrun;

  logic               w_request;
  logic               w_accept;
  logic [PHASE_W-1:0] w_base_phase;

  assign w_request    = sample_tick & en;
  assign w_accept     = w_request & (r_state == IDLE);
  // A sync coincident with an accept makes this sample start from phase 0.
  assign w_base_phase = phase_sync ? '0 : r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_idx      <= '0;
      r_frac     <= '0;
      r_a        <= '0;
      r_rom_addr <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (phase_sync) begin
        r_phase <= '0;
      end
      if (w_request && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx      <= w_base_phase[PHASE_W-1 -: ADDR_W];
            r_frac     <= w_base_phase[PHASE_W-ADDR_W-1 -: FRAC_W];
            r_rom_addr <= w_base_phase[PHASE_W-1 -: ADDR_W];
            r_phase    <= w_base_phase + phase_inc;
            r_busy     <= 1'b1;
            r_state    <= FETCH_A;
          end
        end
        FETCH_A: begin
          r_rom_addr <= r_idx + ADDR_W'(1);
          r_state    <= FETCH_B;
        end
        FETCH_B: begin
          r_a     <= rom_data;
          r_state <= CAP_B;
        end
        // The interpolator takes b straight off rom_data here so the sum is
        // ready when the FSM enters OUT.
        CAP_B: begin
          r_state <= LERP;
        end
        LERP: begin
          r_valid <= 1'b1;
          r_state <= OUT;
        end
        OUT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  lerp #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_lerp (
    .clk      (clk),
    .rst      (rst),
    .i_mul_en (r_state == CAP_B),
    .i_add_en (r_state == LERP),
    .i_a      (r_a),
    .i_b      (rom_data),
    .i_frac   (r_frac),
    .o_result (sample)
  );

  assign rom_addr     = r_rom_addr;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: registered ROM model, directed checks of the
// listed scenarios, then random phase steps against an arithmetic reference.
module tb_wavetable_reader;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int PHASE_W = 32;
  localparam int FRAC_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               sample_tick;
  logic [PHASE_W-1:0] phase_inc;
  logic               phase_sync;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic [DATA_W-1:0]  sample;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  logic [DATA_W-1:0]  rom [0:127];

  int total = 0;
  int bad   = 0;

  bit [31:0] mPhase;
  bit        mOverrun;

  wavetable_reader #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_tick  (sample_tick),
    .phase_inc    (phase_inc),
    .phase_sync   (phase_sync),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Registered ROM: data for an address appears one cycle after it is sampled.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sample: a + floor((b - a) * frac / 256) from the phase fields.
  function automatic logic [31:0] refSample(input bit [31:0] p);
    longint idx, frac, a, b, d, q;
    idx  = longint'(p >> 25);
    frac = longint'((p >> 17) & 32'hFF);
    a    = longint'($signed(rom[idx]));
    b    = longint'($signed(rom[(idx + 1) % 128]));
    d    = (b - a) * frac;
    q    = d / 256;
    if (d < 0 && (d % 256) != 0) q = q - 1;
    return 32'(a + q);
  endfunction

  task automatic resetDut();
    rst = 1'b1; sample_tick = 1'b0; phase_sync = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mPhase   = '0;
    mOverrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idleNoValid", 64'(sample_valid), 64'(0));
    end
  endtask

  // One accepted request; extraTicks[k] drives a tick for the k-th edge after accept.
  task automatic applyStimulus(input logic [31:0] inc, input bit sync, input bit [7:0] extraTicks,
                               input bit dropEn, output logic [31:0] got);
    bit [31:0]   p;
    logic [31:0] exp;
    logic [6:0]  expIdx;
    logic [6:0]  nextIdx;
    int          firstValid;
    int          nValid;
    p          = sync ? 32'h0 : mPhase;
    exp        = refSample(p);
    expIdx     = p[31:25];
    nextIdx    = expIdx + 7'd1;
    mPhase     = p + inc;
    firstValid = 0;
    nValid     = 0;
    got        = '0;
    if (extraTicks != 8'h0) mOverrun = 1'b1;
    sample_tick = 1'b1; phase_inc = inc; phase_sync = sync; en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("busyAfterAccept", 64'(busy), 64'(1));
        checkOutput("romAddrIdx", 64'(rom_addr), 64'(expIdx));
      end
      if (k == 2) checkOutput("romAddrNext", 64'(rom_addr), 64'(nextIdx));
      if (sample_valid) begin
        nValid++;
        if (firstValid == 0) begin
          firstValid = k;
          got = sample;
        end
      end
      if (k == 6) checkOutput("busyLowAfter", 64'(busy), 64'(0));
      sample_tick = extraTicks[k];
      phase_sync  = 1'b0;
      en          = dropEn ? 1'b0 : 1'b1;
    end
    en = 1'b1;
    checkOutput("validCycle", 64'(firstValid), 64'(5));
    checkOutput("validCount", 64'(nValid), 64'(1));
    checkOutput("sampleRef", 64'(got), 64'(exp));
    checkOutput("overrunFlag", 64'(overrun), 64'(mOverrun));
  endtask

  initial begin
    logic [31:0] s;
    bit          syncSel;
    bit [7:0]    mask;
    bit          dropSel;
    for (int i = 0; i < 128; i++) rom[i] = 32'(i * 256);
    rst = 1'b1; en = 1'b0; sample_tick = 1'b0; phase_sync = 1'b0; phase_inc = '0;
    mPhase = '0; mOverrun = 1'b0;

    // Reset held three cycles: every output at zero.
    repeat (3) @(negedge clk);
    checkOutput("rstRomAddr", 64'(rom_addr), 64'(0));
    checkOutput("rstSample", 64'(sample), 64'(0));
    checkOutput("rstValid", 64'(sample_valid), 64'(0));
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstOverrun", 64'(overrun), 64'(0));
    rst = 1'b0; en = 1'b1;
    idleCycles(4);
    checkOutput("idleBusy", 64'(busy), 64'(0));

    // Tick with en low is ignored and does not flag overrun.
    en = 1'b0; sample_tick = 1'b1; phase_inc = 32'h1234_5678;
    @(negedge clk);
    sample_tick = 1'b0; en = 1'b1;
    checkOutput("enLowBusy", 64'(busy), 64'(0));
    idleCycles(6);
    checkOutput("enLowOverrun", 64'(overrun), 64'(0));

    // phase_inc = 0, single tick.
    applyStimulus(32'h0, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t2Sample", 64'(s), 64'(32'h0));

    // Two ticks with phase_inc = 0x0300_0000.
    resetDut();
    applyStimulus(32'h0300_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t3First", 64'(s), 64'(32'h0));
    idleCycles(3);
    applyStimulus(32'h0300_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t3Second", 64'(s), 64'(32'h180));

    // Index wrap from 127 to 0.
    resetDut();
    applyStimulus(32'hFF00_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t4First", 64'(s), 64'(32'h0));
    applyStimulus(32'hFF00_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t4Wrap", 64'(s), 64'(32'h3F80));

    // Overrun: ticks on accept+1 and accept+5 are dropped.
    resetDut();
    applyStimulus(32'h0200_0000, 1'b0, 8'b0010_0010, 1'b0, s);
    checkOutput("t5First", 64'(s), 64'(32'h0));
    idleCycles(3);
    checkOutput("t5Sticky", 64'(overrun), 64'(1));
    applyStimulus(32'h0200_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t5Idx1", 64'(s), 64'(32'h100));

    // Sync coincident with accept after a nonzero phase.
    applyStimulus(32'h0500_0000, 1'b1, 8'h0, 1'b0, s);
    checkOutput("t6Sync", 64'(s), 64'(32'h0));
    applyStimulus(32'h0100_0000, 1'b0, 8'h0, 1'b0, s);
    checkOutput("t6After", 64'(s), 64'(32'h280));

    // Standalone sync, then en dropped mid-operation.
    phase_sync = 1'b1;
    @(negedge clk);
    phase_sync = 1'b0;
    mPhase = '0;
    applyStimulus(32'h0123_4567, 1'b0, 8'h0, 1'b1, s);
    checkOutput("syncAloneSample", 64'(s), 64'(32'h0));

    // Reset mid-operation: back to reset values, no sample_valid.
    sample_tick = 1'b1; phase_inc = 32'h0300_0000;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mPhase = '0; mOverrun = 1'b0;
    checkOutput("midRstBusy", 64'(busy), 64'(0));
    checkOutput("midRstSample", 64'(sample), 64'(0));
    checkOutput("midRstAddr", 64'(rom_addr), 64'(0));
    checkOutput("midRstOverrun", 64'(overrun), 64'(0));
    idleCycles(6);

    // Random table contents and random phase steps.
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    resetDut();
    for (int it = 0; it < 40; it++) begin
      syncSel = ($urandom_range(0, 7) == 0);
      mask    = ($urandom_range(0, 3) == 0) ? (8'h1 << $urandom_range(1, 5)) : 8'h0;
      dropSel = (mask == 8'h0) && ($urandom_range(0, 3) == 0);
      applyStimulus($urandom, syncSel, mask, dropSel, s);
      if ($urandom_range(0, 5) == 0) begin
        phase_sync = 1'b1;
        @(negedge clk);
        phase_sync = 1'b0;
        mPhase = '0;
      end
      idleCycles($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
